combo_lock_fsm: RTL and testbench
=================================

# combo_lock_fsm

Code-entry lock controller that sits directly downstream of the rotational encoder and directly upstream of the seven-segment driver. It takes the encoder's 4-bit dial value and one-cycle push-button events, and accepts a four-digit code one digit at a time. It checks the code against the stored code and drives the open, fail and lockout sequencing. Its 16-bit `display_value` feeds the seven-segment block's `display_value` input.

## Interface
- `CODE`, 16'h1234: reset/default unlock code; digit 0 (first entered) in [15:12].
- `OPEN_CYCLES`, 32'd50_000_000: clocks spent in OPEN before relocking.
- `FAIL_CYCLES`, 32'd25_000_000: clocks spent in FAIL.
- `LOCKOUT_CYCLES`, 32'd250_000_000: clocks spent in LOCKOUT.
- `MAX_FAILS`, 3: consecutive failures that trigger LOCKOUT (1..7).

Ports:
- `clk`  in  1  system clock; all state updates on its rising edge.
- `rstn`  in  1  asynchronous active-low reset.
- `enc`  in  4  current dial value from the encoder.
- `pb_press_type`  in  2  button event, valid for exactly one clock when nonzero: 00 none, 01 short, 10 long, 11 double.
- `display_value`  out  16  four hex nibbles to the seven-segment driver.
- `digit_idx`  out  2  index of the next digit to enter.
- `unlocked`  out  1  high only in OPEN.
- `alarm`  out  1  high only in LOCKOUT.
- `fail_cnt`  out  3  consecutive failure count.

## Operation
- States: ENTRY, CHECK, OPEN, FAIL, LOCKOUT. Reset state is ENTRY.
- Reset values: `display_value`=0, `digit_idx`=0, `unlocked`=0, `alarm`=0, `fail_cnt`=0. Entry register=0, timer=0, stored code=`CODE`.
- **ENTRY**
  - Short press: shift `enc` into the entry register LSB (entry <= {entry[11:0], enc}) and increment `digit_idx`.
  - If the short press commits the fourth digit (`digit_idx`==3): `digit_idx` wraps to 0 and the next state is CHECK.
  - Long press: clear the entry register and set `digit_idx`=0.
  - Double press: ignored.
  - `display_value` = entry register.
- **CHECK** (exactly one cycle)
  - Entry == stored code: go to OPEN, set `fail_cnt`=0.
  - Otherwise: increment `fail_cnt`, saturating at 7.
  - After a mismatch, if the new `fail_cnt` >= `MAX_FAILS`, go to LOCKOUT; else go to FAIL.
  - The entry register clears on leaving CHECK.
- **OPEN**
  - `display_value`=16'hAAAA; `unlocked`=1.
  - Returns to ENTRY after `OPEN_CYCLES` clocks, or immediately on a long press.
  - Short press: ignored.
  - Double press: see Configuration.
- **FAIL**: `display_value`=16'hEEEE. Returns to ENTRY after `FAIL_CYCLES` clocks. All presses ignored.
- **LOCKOUT**
  - `display_value`=16'hDDDD; `alarm`=1.
  - Returns to ENTRY after `LOCKOUT_CYCLES` clocks with `fail_cnt` cleared. All presses ignored.
- Timer: a 32-bit down-counter, loaded with N-1 on entry to a timed state. The state exits on the cycle the counter reads 0, so the state lasts exactly N clocks.
- `enc` is sampled only on a short-press cycle; changes to `enc` at any other time have no effect.
- Async reset asserted mid-operation (any state, any timer value) returns all registers to their reset values immediately. The stored code also reverts to `CODE`.

## Timing
- All outputs are registered.
- A press in cycle t is reflected in `display_value` and `digit_idx` at t+1.
- Fourth short press at t:
  - CHECK at t+1.
  - OPEN/FAIL/LOCKOUT state, `unlocked`/`alarm` and `display_value` valid at t+2.
  - Total latency is 2 clocks.
- Timed-state exit: ENTRY is visible N clocks after entering the state.
- Ports carry no handshake: `pb_press_type` is a one-cycle event stream and must not be held.

## Configuration
- `COMBO_LOCK_PROGRAM_EN` defined:
  - A double press in OPEN enters an extra state PROGRAM: `display_value` = entry register, `unlocked`=1.
  - Short presses shift digits in, exactly as in ENTRY.
  - After the fourth digit, the stored code is replaced with the entry and the next state is ENTRY.
  - A long press in PROGRAM aborts to ENTRY with the code unchanged.
  - The `OPEN_CYCLES` timeout does not apply in PROGRAM.
- Not defined:
  - The stored code is the constant `CODE`.
  - A double press in OPEN is ignored.
  - No PROGRAM state or storage register exists.

## Test plan
- Bench parameters: `CODE`=16'h1234, `OPEN_CYCLES`=10, `FAIL_CYCLES`=4, `LOCKOUT_CYCLES`=20, `MAX_FAILS`=3.
- Correct code: short presses with `enc`=1,2,3,4 → `display_value` steps 0001, 0012, 0123; `unlocked`=1 and `display_value`=AAAA two clocks after the last press, high for exactly 10 clocks, then ENTRY with `display_value`=0.
- Wrong code 1,2,3,5 → `display_value`=EEEE for 4 clocks, `fail_cnt`=1; then the correct code → OPEN with `fail_cnt`=0.
- Three consecutive wrong codes → third gives `alarm`=1 and DDDD for 20 clocks; presses during lockout ignored; then `fail_cnt`=0 and ENTRY.
- Entry 1,2 then long press → `display_value`=0, `digit_idx`=0; subsequent 1,2,3,4 opens. Long press in OPEN → ENTRY next clock.
- `rstn` low mid-LOCKOUT and mid-ENTRY → all outputs 0 immediately, stored code=1234.
- With `COMBO_LOCK_PROGRAM_EN`:
  - Open, double press, enter 9,8,7,6 → ENTRY; 1,2,3,4 now fails; 9,8,7,6 opens.
  - Without the macro, the same double press leaves the lock in OPEN.

Source files
------------

// File: rtl/combo_lock_fsm.sv
// rtl/combo_lock_fsm.sv - four-digit code lock FSM; optional code reprogramming under COMBO_LOCK_PROGRAM_EN
module combo_lock_fsm #(
    parameter logic [15:0] CODE           = 16'h1234,
    parameter logic [31:0] OPEN_CYCLES    = 32'd50_000_000,
    parameter logic [31:0] FAIL_CYCLES    = 32'd25_000_000,
    parameter logic [31:0] LOCKOUT_CYCLES = 32'd250_000_000,
    parameter int unsigned MAX_FAILS      = 3
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [3:0]  enc,
    input  logic [1:0]  pb_press_type,
    output logic [15:0] display_value,
    output logic [1:0]  digit_idx,
    output logic        unlocked,
    output logic        alarm,
    output logic [2:0]  fail_cnt
);

`ifdef COMBO_LOCK_PROGRAM_EN
    typedef enum logic [2:0] {
        ST_ENTRY, ST_CHECK, ST_OPEN, ST_FAIL, ST_LOCKOUT, ST_PROGRAM
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_ENTRY, ST_CHECK, ST_OPEN, ST_FAIL, ST_LOCKOUT
    } state_t;
`endif

    state_t      state_q, state_d;
    logic [15:0] entry_q, entry_d;
    logic [1:0]  idx_q, idx_d;
    logic [31:0] timer_q, timer_d;
    logic [2:0]  fail_q, fail_d;
    logic [15:0] disp_q, disp_d;
    logic        unl_q, unl_d;
    logic        alarm_q, alarm_d;
    logic [15:0] code_cur;
    logic [2:0]  fail_inc;
    logic        is_short, is_long;

    assign is_short = (pb_press_type == 2'b01);
    assign is_long  = (pb_press_type == 2'b10);
    assign fail_inc = (fail_q == 3'd7) ? 3'd7 : fail_q + 3'd1;

`ifdef COMBO_LOCK_PROGRAM_EN
    logic [15:0] code_q, code_d;
    logic        is_double;
    assign is_double = (pb_press_type == 2'b11);
    assign code_cur  = code_q;
`else
    assign code_cur  = CODE;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_ENTRY;
            entry_q <= 16'h0000;
            idx_q   <= 2'd0;
            timer_q <= 32'd0;
            fail_q  <= 3'd0;
            disp_q  <= 16'h0000;
            unl_q   <= 1'b0;
            alarm_q <= 1'b0;
`ifdef COMBO_LOCK_PROGRAM_EN
            code_q  <= CODE;
`endif
        end else begin
            state_q <= state_d;
            entry_q <= entry_d;
            idx_q   <= idx_d;
            timer_q <= timer_d;
            fail_q  <= fail_d;
            disp_q  <= disp_d;
            unl_q   <= unl_d;
            alarm_q <= alarm_d;
`ifdef COMBO_LOCK_PROGRAM_EN
            code_q  <= code_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        entry_d = entry_q;
        idx_d   = idx_q;
        timer_d = timer_q;
        fail_d  = fail_q;
`ifdef COMBO_LOCK_PROGRAM_EN
        code_d  = code_q;
`endif
        case (state_q)
            ST_ENTRY: begin
                if (is_short) begin
                    entry_d = {entry_q[11:0], enc};
                    idx_d   = idx_q + 2'd1;
                    if (idx_q == 2'd3) state_d = ST_CHECK;
                end else if (is_long) begin
                    entry_d = 16'h0000;
                    idx_d   = 2'd0;
                end
            end
            ST_CHECK: begin
                entry_d = 16'h0000;
                idx_d   = 2'd0;
                if (entry_q == code_cur) begin
                    fail_d  = 3'd0;
                    state_d = ST_OPEN;
                    timer_d = OPEN_CYCLES - 32'd1;
                end else begin
                    fail_d = fail_inc;
                    if ({29'd0, fail_inc} >= MAX_FAILS) begin
                        state_d = ST_LOCKOUT;
                        timer_d = LOCKOUT_CYCLES - 32'd1;
                    end else begin
                        state_d = ST_FAIL;
                        timer_d = FAIL_CYCLES - 32'd1;
                    end
                end
            end
            ST_OPEN: begin
                if (is_long) begin
                    state_d = ST_ENTRY;
`ifdef COMBO_LOCK_PROGRAM_EN
                end else if (is_double) begin
                    state_d = ST_PROGRAM;
                    entry_d = 16'h0000;
                    idx_d   = 2'd0;
`endif
                end else if (timer_q == 32'd0) begin
                    state_d = ST_ENTRY;
                end else begin
                    timer_d = timer_q - 32'd1;
                end
            end
            ST_FAIL: begin
                if (timer_q == 32'd0) state_d = ST_ENTRY;
                else                  timer_d = timer_q - 32'd1;
            end
            ST_LOCKOUT: begin
                if (timer_q == 32'd0) begin
                    state_d = ST_ENTRY;
                    fail_d  = 3'd0;
                end else begin
                    timer_d = timer_q - 32'd1;
                end
            end
`ifdef COMBO_LOCK_PROGRAM_EN
            ST_PROGRAM: begin
                // No timeout here: the operator stays until four digits or an abort.
                if (is_short) begin
                    entry_d = {entry_q[11:0], enc};
                    idx_d   = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        code_d  = {entry_q[11:0], enc};
                        entry_d = 16'h0000;
                        state_d = ST_ENTRY;
                    end
                end else if (is_long) begin
                    entry_d = 16'h0000;
                    idx_d   = 2'd0;
                    state_d = ST_ENTRY;
                end
            end
`endif
            default: begin
                state_d = ST_ENTRY;
                entry_d = 16'h0000;
                idx_d   = 2'd0;
            end
        endcase

        // Outputs are registered from the next state so they line up with it.
        disp_d  = entry_d;
        unl_d   = 1'b0;
        alarm_d = 1'b0;
        case (state_d)
            ST_OPEN: begin
                disp_d = 16'hAAAA;
                unl_d  = 1'b1;
            end
            ST_FAIL:    disp_d = 16'hEEEE;
            ST_LOCKOUT: begin
                disp_d  = 16'hDDDD;
                alarm_d = 1'b1;
            end
`ifdef COMBO_LOCK_PROGRAM_EN
            ST_PROGRAM: unl_d = 1'b1;
`endif
            default: disp_d = entry_d;
        endcase
    end

    assign display_value = disp_q;
    assign digit_idx     = idx_q;
    assign unlocked      = unl_q;
    assign alarm         = alarm_q;
    assign fail_cnt      = fail_q;

endmodule

// File: tb/tb_combo_lock_fsm.sv
// tb/tb_combo_lock_fsm.sv - self-checking bench for combo_lock_fsm
module tb_combo_lock_fsm;
    localparam logic [15:0] CODE  = 16'h1234;
    localparam int OPEN_N = 10;
    localparam int FAIL_N = 4;
    localparam int LOCK_N = 20;
    localparam int MAXF   = 3;
`ifdef COMBO_LOCK_PROGRAM_EN
    localparam bit PROG = 1'b1;
`else
    localparam bit PROG = 1'b0;
`endif
    localparam logic [1:0] P_NONE = 2'b00, P_SHORT = 2'b01, P_LONG = 2'b10, P_DBL = 2'b11;

    logic        clk = 1'b0;
    logic        rstn;
    logic [3:0]  enc;
    logic [1:0]  pb;
    logic [15:0] display_value;
    logic [1:0]  digit_idx;
    logic        unlocked, alarm;
    logic [2:0]  fail_cnt;

    combo_lock_fsm #(
        .CODE(CODE), .OPEN_CYCLES(32'd10), .FAIL_CYCLES(32'd4),
        .LOCKOUT_CYCLES(32'd20), .MAX_FAILS(3)
    ) dut (
        .clk(clk), .rstn(rstn), .enc(enc), .pb_press_type(pb),
        .display_value(display_value), .digit_idx(digit_idx),
        .unlocked(unlocked), .alarm(alarm), .fail_cnt(fail_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errs   = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference model: operating mode, digits typed so far, cycles left in a timed mode.
    localparam int M_ENTRY = 0, M_CHECK = 1, M_OPEN = 2, M_FAIL = 3, M_LOCK = 4, M_PROG = 5;
    int          m_mode;
    logic [3:0]  m_q[$];
    int          m_left;
    int          m_fails;
    logic [15:0] m_code;

    function automatic logic [15:0] packq();
        logic [15:0] v = 16'h0000;
        foreach (m_q[i]) v = {v[11:0], m_q[i]};
        return v;
    endfunction

    task automatic model_reset();
        m_mode = M_ENTRY; m_q.delete(); m_left = 0; m_fails = 0; m_code = CODE;
    endtask

    task automatic model_step(input logic [1:0] p, input logic [3:0] e);
        case (m_mode)
            M_ENTRY: begin
                if (p == P_SHORT) begin
                    m_q.push_back(e);
                    if (m_q.size() == 4) m_mode = M_CHECK;
                end else if (p == P_LONG) m_q.delete();
            end
            M_CHECK: begin
                if (packq() == m_code) begin
                    m_fails = 0; m_mode = M_OPEN; m_left = OPEN_N;
                end else begin
                    m_fails = (m_fails >= 7) ? 7 : m_fails + 1;
                    if (m_fails >= MAXF) begin m_mode = M_LOCK; m_left = LOCK_N; end
                    else begin m_mode = M_FAIL; m_left = FAIL_N; end
                end
                m_q.delete();
            end
            M_OPEN: begin
                if (p == P_LONG) m_mode = M_ENTRY;
                else if (PROG && p == P_DBL) m_mode = M_PROG;
                else begin
                    m_left--;
                    if (m_left == 0) m_mode = M_ENTRY;
                end
            end
            M_FAIL: begin
                m_left--;
                if (m_left == 0) m_mode = M_ENTRY;
            end
            M_LOCK: begin
                m_left--;
                if (m_left == 0) begin m_mode = M_ENTRY; m_fails = 0; end
            end
            default: begin
                if (p == P_SHORT) begin
                    m_q.push_back(e);
                    if (m_q.size() == 4) begin
                        m_code = packq(); m_q.delete(); m_mode = M_ENTRY;
                    end
                end else if (p == P_LONG) begin
                    m_q.delete(); m_mode = M_ENTRY;
                end
            end
        endcase
    endtask

    function automatic logic [22:0] model_out();
        logic [15:0] d;
        case (m_mode)
            M_OPEN:  d = 16'hAAAA;
            M_FAIL:  d = 16'hEEEE;
            M_LOCK:  d = 16'hDDDD;
            default: d = packq();
        endcase
        return {d, 2'(m_q.size() % 4), (m_mode == M_OPEN || m_mode == M_PROG),
                (m_mode == M_LOCK), 3'(m_fails)};
    endfunction

    function automatic logic [22:0] dut_out();
        return {display_value, digit_idx, unlocked, alarm, fail_cnt};
    endfunction

    task automatic step(input logic [1:0] p, input logic [3:0] e);
        pb = p; enc = e;
        @(posedge clk);
        model_step(p, e);
        #1;
        pb = P_NONE; enc = 4'($urandom);
    endtask

    task automatic enter_code(input logic [15:0] c);
        for (int i = 3; i >= 0; i--) step(P_SHORT, c[4*i +: 4]);
    endtask

    task automatic wait_entry(input string name);
        int n = 0;
        while ((unlocked || alarm || display_value == 16'hEEEE) && n < 40) begin
            step(P_NONE, 4'h0); n++;
        end
        chk(name, 32'(n < 40), 32'd1);
    endtask

    task automatic async_reset_check(input string name);
        #3 rstn = 1'b0;
        #1 chk(name, 32'(dut_out()), 32'd0);
        model_reset();
        #2 rstn = 1'b1;
        step(P_NONE, 4'h0);
    endtask

    typedef struct {
        logic [1:0]  p;
        logic [3:0]  e;
        logic [15:0] disp;
        logic [1:0]  idx;
        logic        unl;
        logic        alm;
        logic [2:0]  fc;
    } vec_t;
    vec_t tbl[$];

    task automatic addv(input logic [1:0] p, input logic [3:0] e, input logic [15:0] d,
                        input logic [1:0] i, input logic u, input logic fc0);
        vec_t v;
        v.p = p; v.e = e; v.disp = d; v.idx = i; v.unl = u; v.alm = 1'b0; v.fc = {2'b00, fc0};
        tbl.push_back(v);
    endtask

    initial begin
        int cnt;
        rstn = 1'b0; pb = P_NONE; enc = 4'h0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 chk("reset_state", 32'(dut_out()), 32'd0);
        rstn = 1'b1;

        addv(P_SHORT, 4'h1, 16'h0001, 2'd1, 0, 0);
        addv(P_SHORT, 4'h2, 16'h0012, 2'd2, 0, 0);
        addv(P_LONG,  4'h7, 16'h0000, 2'd0, 0, 0);
        addv(P_SHORT, 4'h1, 16'h0001, 2'd1, 0, 0);
        addv(P_SHORT, 4'h2, 16'h0012, 2'd2, 0, 0);
        addv(P_DBL,   4'h9, 16'h0012, 2'd2, 0, 0);
        addv(P_NONE,  4'h7, 16'h0012, 2'd2, 0, 0);
        addv(P_SHORT, 4'h3, 16'h0123, 2'd3, 0, 0);
        addv(P_SHORT, 4'h4, 16'h1234, 2'd0, 0, 0);
        addv(P_NONE,  4'h0, 16'hAAAA, 2'd0, 1, 0);
        addv(P_SHORT, 4'h5, 16'hAAAA, 2'd0, 1, 0);
        addv(P_LONG,  4'h0, 16'h0000, 2'd0, 0, 0);
        addv(P_SHORT, 4'h1, 16'h0001, 2'd1, 0, 0);
        addv(P_SHORT, 4'h2, 16'h0012, 2'd2, 0, 0);
        addv(P_SHORT, 4'h3, 16'h0123, 2'd3, 0, 0);
        addv(P_SHORT, 4'h5, 16'h1235, 2'd0, 0, 0);
        addv(P_NONE,  4'h0, 16'hEEEE, 2'd0, 0, 1);
        addv(P_LONG,  4'h0, 16'hEEEE, 2'd0, 0, 1);
        addv(P_SHORT, 4'h3, 16'hEEEE, 2'd0, 0, 1);
        addv(P_NONE,  4'h0, 16'hEEEE, 2'd0, 0, 1);
        addv(P_NONE,  4'h0, 16'h0000, 2'd0, 0, 1);
        addv(P_SHORT, 4'h1, 16'h0001, 2'd1, 0, 1);
        addv(P_SHORT, 4'h2, 16'h0012, 2'd2, 0, 1);
        addv(P_SHORT, 4'h3, 16'h0123, 2'd3, 0, 1);
        addv(P_SHORT, 4'h4, 16'h1234, 2'd0, 0, 1);
        addv(P_NONE,  4'h0, 16'hAAAA, 2'd0, 1, 0);
        addv(P_LONG,  4'h0, 16'h0000, 2'd0, 0, 0);
        foreach (tbl[i]) begin
            step(tbl[i].p, tbl[i].e);
            chk($sformatf("vec%0d", i), 32'(dut_out()),
                32'({tbl[i].disp, tbl[i].idx, tbl[i].unl, tbl[i].alm, tbl[i].fc}));
        end

        // Open window lasts exactly OPEN_N clocks, starting two clocks after the last press.
        enter_code(16'h1234);
        chk("check_cycle_locked", 32'(unlocked), 32'd0);
        step(P_NONE, 4'h0);
        chk("open_disp", 32'(display_value), 32'hAAAA);
        cnt = 1;
        for (int i = 0; i < 40 && unlocked; i++) begin
            step(P_NONE, 4'h0);
            if (unlocked) cnt++;
        end
        chk("open_len", cnt, OPEN_N);
        chk("open_exit_disp", 32'(display_value), 32'h0);

        // Three consecutive failures -> lockout, presses ignored, count cleared on exit.
        for (int k = 0; k < 3; k++) begin
            enter_code(16'h1235);
            step(P_NONE, 4'h0);
            chk($sformatf("fail_cnt_%0d", k), 32'(fail_cnt), 32'(k + 1));
            if (k < 2) wait_entry("fail_exit");
        end
        chk("lockout_alarm", 32'({display_value, alarm}), 32'({16'hDDDD, 1'b1}));
        cnt = 1;
        for (int i = 0; i < 60 && alarm; i++) begin
            step(2'($urandom_range(0, 3)), 4'($urandom));
            if (alarm) cnt++;
        end
        chk("lockout_len", cnt, LOCK_N);
        chk("lockout_exit", 32'(dut_out()), 32'd0);

        // Async reset mid-lockout and mid-entry.
        for (int k = 0; k < 3; k++) begin
            enter_code(16'h1235);
            step(P_NONE, 4'h0);
            if (k < 2) wait_entry("fail_exit2");
        end
        repeat (5) step(P_NONE, 4'h0);
        async_reset_check("reset_mid_lockout");
        step(P_SHORT, 4'h1);
        step(P_SHORT, 4'h2);
        async_reset_check("reset_mid_entry");
        enter_code(16'h1234);
        step(P_NONE, 4'h0);
        chk("code_after_reset", 32'(unlocked), 32'd1);

`ifdef COMBO_LOCK_PROGRAM_EN
        step(P_DBL, 4'h0);
        chk("prog_enter", 32'({display_value, unlocked}), 32'({16'h0000, 1'b1}));
        enter_code(16'h9876);
        chk("prog_done", 32'({display_value, digit_idx, unlocked}), 32'd0);
        enter_code(16'h1234);
        step(P_NONE, 4'h0);
        chk("old_code_fails", 32'(display_value), 32'hEEEE);
        wait_entry("prog_fail_exit");
        enter_code(16'h9876);
        step(P_NONE, 4'h0);
        chk("new_code_opens", 32'(unlocked), 32'd1);
        step(P_LONG, 4'h0);
        async_reset_check("reset_after_prog");
        enter_code(16'h1234);
        step(P_NONE, 4'h0);
        chk("code_reverts", 32'(unlocked), 32'd1);
`else
        step(P_DBL, 4'h0);
        chk("dbl_in_open", 32'({display_value, unlocked}), 32'({16'hAAAA, 1'b1}));
`endif
        step(P_LONG, 4'h0);
        chk("long_in_open", 32'({display_value, unlocked}), 32'd0);

        // Random phase against the reference model.
        for (int i = 0; i < 3000; i++) begin
            int r;
            logic [1:0] p;
            logic [3:0] e;
            r = $urandom_range(0, 99);
            p = (r < 60) ? P_NONE : (r < 85) ? P_SHORT : (r < 93) ? P_LONG : P_DBL;
            if ($urandom_range(0, 1) == 1) e = m_code[4*(3 - (m_q.size() % 4)) +: 4];
            else                           e = 4'($urandom);
            step(p, e);
            chk($sformatf("rand%0d", i), 32'(dut_out()), 32'(model_out()));
        end

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end
endmodule
